// File: rtl/ram_s2p1c_be.sv
// Simple dual-port RAM, single clock: port A writes with byte enables, port B reads
// with 1- or 2-cycle latency, selectable read-during-write policy and a fill engine.
module ram_s2p1c_be #(
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned WORD_COUNT     = 256,
  parameter int unsigned BYTE_WIDTH     = 8,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter logic [WORD_WIDTH-1:0] CLEAR_VALUE = '0,
  localparam int unsigned ADDR_WIDTH = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1,
  localparam int unsigned BE_WIDTH   = WORD_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  output logic                  ready_o,
  input  logic                  we_a_i,
  input  logic [BE_WIDTH-1:0]   be_a_i,
  input  logic [ADDR_WIDTH-1:0] addr_a_i,
  input  logic [WORD_WIDTH-1:0] data_a_i,
  input  logic                  re_b_i,
  input  logic [ADDR_WIDTH-1:0] addr_b_i,
  output logic [WORD_WIDTH-1:0] data_b_o,
  output logic                  valid_b_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR    = ADDR_WIDTH'(WORD_COUNT - 1);
  localparam logic [ADDR_WIDTH:0]   WORD_COUNT_W = (ADDR_WIDTH + 1)'(WORD_COUNT);

  // Elaboration-time parameter legality
  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
    $error("ram_s2p1c_be: READ_LATENCY must be 1 or 2");
  end
  if ((WORD_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_byte
    $error("ram_s2p1c_be: WORD_WIDTH must be a multiple of BYTE_WIDTH");
  end

  logic [WORD_WIDTH-1:0] mem [WORD_COUNT];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ready_q, ready_d;

  logic                  addr_a_ok_c, addr_b_ok_c;
  logic                  wr_en_c, rd_en_c;
  logic [WORD_WIDTH-1:0] rd_word_c;

  logic                  v1_q;
  logic [WORD_WIDTH-1:0] d1_q;

  assign addr_a_ok_c = ({1'b0, addr_a_i} < WORD_COUNT_W);
  assign addr_b_ok_c = ({1'b0, addr_b_i} < WORD_COUNT_W);
  assign wr_en_c     = ready_q & we_a_i & addr_a_ok_c;
  assign rd_en_c     = ready_q & re_b_i;
  assign ready_o     = ready_q;

  // Clear FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      ready_q <= (RST_STATE == ST_IDLE);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Clear FSM next state; clear_i is only honoured from IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // Array write port: clear engine owns the port while clearing
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == ST_CLEAR) begin
        mem[cnt_q] <= CLEAR_VALUE;
      end else if (wr_en_c) begin
        for (int k = 0; k < int'(BE_WIDTH); k++) begin
          if (be_a_i[k]) begin
            mem[addr_a_i][k*BYTE_WIDTH +: BYTE_WIDTH] <= data_a_i[k*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end
  end

  // Read word with optional per-byte forwarding of a same-cycle write
  always_comb begin
    rd_word_c = '0;
    if (addr_b_ok_c) begin
      rd_word_c = mem[addr_b_i];
      if ((RDW_MODE != 0) && wr_en_c && (addr_a_i == addr_b_i)) begin
        for (int k = 0; k < int'(BE_WIDTH); k++) begin
          if (be_a_i[k]) begin
            rd_word_c[k*BYTE_WIDTH +: BYTE_WIDTH] = data_a_i[k*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end
  end

  // Read stage 1; data holds when no read is accepted
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= rd_en_c;
      if (rd_en_c) begin
        d1_q <= rd_word_c;
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_rl2
    logic                  v2_q;
    logic [WORD_WIDTH-1:0] d2_q;

    // Pure retiming stage: no forwarding from later writes
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) begin
          d2_q <= d1_q;
        end
      end
    end

    assign valid_b_o = v2_q;
    assign data_b_o  = d2_q;
  end else begin : g_rl1
    assign valid_b_o = v1_q;
    assign data_b_o  = d1_q;
  end

  // Interface sanity outside reset
  a_ctrl_known: assert property (@(posedge clk_i) disable iff (rst_i)
    !$isunknown({we_a_i, re_b_i, clear_i}));
  a_wr_known: assert property (@(posedge clk_i) disable iff (rst_i)
    we_a_i |-> !$isunknown({addr_a_i, be_a_i}));
  a_rd_known: assert property (@(posedge clk_i) disable iff (rst_i)
    re_b_i |-> !$isunknown(addr_b_i));

endmodule

// File: tb/tb_ram_s2p1c_be.sv
// Directed bench for ram_s2p1c_be: three instances (lat1/old-data, lat2/forwarding,
// 200-word with non-zero fill) share one stimulus stream.
module tb_ram_s2p1c_be;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        rst, clear, we, re;
  logic [3:0]  be;
  logic [7:0]  waddr, raddr;
  logic [31:0] wdata;

  logic        rdy_a, rdy_b, rdy_c;
  logic        vld_a, vld_b, vld_c;
  logic [31:0] dout_a, dout_b, dout_c;

  localparam logic [31:0] FILL_C = 32'h5A5A_A5A5;

  ram_s2p1c_be #(.READ_LATENCY(1), .RDW_MODE(0), .WORD_COUNT(256)) u_a (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .ready_o(rdy_a),
    .we_a_i(we), .be_a_i(be), .addr_a_i(waddr), .data_a_i(wdata),
    .re_b_i(re), .addr_b_i(raddr), .data_b_o(dout_a), .valid_b_o(vld_a));

  ram_s2p1c_be #(.READ_LATENCY(2), .RDW_MODE(1), .WORD_COUNT(256)) u_b (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .ready_o(rdy_b),
    .we_a_i(we), .be_a_i(be), .addr_a_i(waddr), .data_a_i(wdata),
    .re_b_i(re), .addr_b_i(raddr), .data_b_o(dout_b), .valid_b_o(vld_b));

  ram_s2p1c_be #(.READ_LATENCY(1), .RDW_MODE(0), .WORD_COUNT(200), .CLEAR_VALUE(FILL_C)) u_c (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .ready_o(rdy_c),
    .we_a_i(we), .be_a_i(be), .addr_a_i(waddr), .data_a_i(wdata),
    .re_b_i(re), .addr_b_i(raddr), .data_b_o(dout_c), .valid_b_o(vld_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    we = 1'b1; waddr = a; wdata = d; be = m;
    tick();
    we = 1'b0;
  endtask

  // One read: latency-1 instances sampled after one edge, latency-2 after two
  task automatic do_read(input logic [7:0] a, output logic [32:0] ra, output logic [32:0] rb,
                         output logic [32:0] rc);
    re = 1'b1; raddr = a;
    tick();
    re = 1'b0;
    ra = {vld_a, dout_a};
    rc = {vld_c, dout_c};
    tick();
    rb = {vld_b, dout_b};
  endtask

  task automatic wait_ready(output int ra, output int rb, output int rc);
    ra = 0; rb = 0; rc = 0;
    for (int n = 1; n <= 400; n++) begin
      tick();
      if (ra == 0 && rdy_a) ra = n;
      if (rb == 0 && rdy_b) rb = n;
      if (rc == 0 && rdy_c) rc = n;
      if (ra != 0 && rb != 0 && rc != 0) break;
    end
  endtask

  task automatic test_reset();
    int ra, rb, rc;
    rst = 1'b1;
    tick();
    tick();
    checks++; if ({rdy_a, vld_a, dout_a} !== 34'd0) begin failures++; $display("FAIL reset_a: got %h want 0", {rdy_a, vld_a, dout_a}); end
    checks++; if ({rdy_b, vld_b, dout_b} !== 34'd0) begin failures++; $display("FAIL reset_b: got %h want 0", {rdy_b, vld_b, dout_b}); end
    checks++; if ({rdy_c, vld_c, dout_c} !== 34'd0) begin failures++; $display("FAIL reset_c: got %h want 0", {rdy_c, vld_c, dout_c}); end
    rst = 1'b0;
    wait_ready(ra, rb, rc);
    checks++; if (ra != 256) begin failures++; $display("FAIL reset_ready_a: got %0d want 256", ra); end
    checks++; if (rb != 256) begin failures++; $display("FAIL reset_ready_b: got %0d want 256", rb); end
    checks++; if (rc != 200) begin failures++; $display("FAIL reset_ready_c: got %0d want 200", rc); end
    // Stream reads over the whole address space, one per cycle
    for (int k = 0; k < 258; k++) begin
      re = (k < 256);
      raddr = 8'(k);
      tick();
      if (k < 256) begin
        checks++; if ({vld_a, dout_a} !== {1'b1, 32'h0}) begin failures++; $display("FAIL clear_rd_a[%0d]: got %h want 100000000", k, {vld_a, dout_a}); end
        checks++;
        if ({vld_c, dout_c} !== {1'b1, (k < 200) ? FILL_C : 32'h0}) begin
          failures++; $display("FAIL clear_rd_c[%0d]: got %h want %h", k, {vld_c, dout_c}, {1'b1, (k < 200) ? FILL_C : 32'h0});
        end
      end
      if (k >= 1) begin
        checks++; if ({vld_b, dout_b} !== {(k <= 256), 32'h0}) begin failures++; $display("FAIL clear_rd_b[%0d]: got %h want %h", k, {vld_b, dout_b}, {(k <= 256), 32'h0}); end
      end
    end
    re = 1'b0;
  endtask

  task automatic test_byte_enable();
    logic [32:0] ra, rb, rc;
    do_write(8'd5, 32'hAABB_CCDD, 4'b1111);
    do_write(8'd5, 32'h1122_3344, 4'b0101);
    do_write(8'd5, 32'hFFFF_FFFF, 4'b0000);
    do_read(8'd5, ra, rb, rc);
    checks++; if (ra !== {1'b1, 32'hAA22_CC44}) begin failures++; $display("FAIL be_a: got %h want 1aa22cc44", ra); end
    checks++; if (rb !== {1'b1, 32'hAA22_CC44}) begin failures++; $display("FAIL be_b: got %h want 1aa22cc44", rb); end
    checks++; if (rc !== {1'b1, 32'hAA22_CC44}) begin failures++; $display("FAIL be_c: got %h want 1aa22cc44", rc); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3];
    w[0] = 32'h0A0A_0A00; w[1] = 32'h0A0A_0A01; w[2] = 32'h0A0A_0A02;
    for (int i = 0; i < 3; i++) do_write(8'(i), w[i], 4'b1111);
    tick();
    re = 1'b1; raddr = 8'd0;
    tick();
    raddr = 8'd1;
    checks++; if ({vld_a, dout_a} !== {1'b1, w[0]}) begin failures++; $display("FAIL b2b_a_t1: got %h want %h", {vld_a, dout_a}, {1'b1, w[0]}); end
    checks++; if ({vld_c, dout_c} !== {1'b1, w[0]}) begin failures++; $display("FAIL b2b_c_t1: got %h want %h", {vld_c, dout_c}, {1'b1, w[0]}); end
    checks++; if (vld_b !== 1'b0) begin failures++; $display("FAIL b2b_b_t1: got valid %b want 0", vld_b); end
    tick();
    raddr = 8'd2;
    checks++; if ({vld_a, dout_a} !== {1'b1, w[1]}) begin failures++; $display("FAIL b2b_a_t2: got %h want %h", {vld_a, dout_a}, {1'b1, w[1]}); end
    checks++; if ({vld_b, dout_b} !== {1'b1, w[0]}) begin failures++; $display("FAIL b2b_b_t2: got %h want %h", {vld_b, dout_b}, {1'b1, w[0]}); end
    tick();
    re = 1'b0;
    checks++; if ({vld_a, dout_a} !== {1'b1, w[2]}) begin failures++; $display("FAIL b2b_a_t3: got %h want %h", {vld_a, dout_a}, {1'b1, w[2]}); end
    checks++; if ({vld_b, dout_b} !== {1'b1, w[1]}) begin failures++; $display("FAIL b2b_b_t3: got %h want %h", {vld_b, dout_b}, {1'b1, w[1]}); end
    tick();
    checks++; if ({vld_a, dout_a} !== {1'b0, w[2]}) begin failures++; $display("FAIL b2b_a_hold: got %h want %h", {vld_a, dout_a}, {1'b0, w[2]}); end
    checks++; if ({vld_b, dout_b} !== {1'b1, w[2]}) begin failures++; $display("FAIL b2b_b_t4: got %h want %h", {vld_b, dout_b}, {1'b1, w[2]}); end
    tick();
    checks++; if ({vld_b, dout_b} !== {1'b0, w[2]}) begin failures++; $display("FAIL b2b_b_hold: got %h want %h", {vld_b, dout_b}, {1'b0, w[2]}); end
  endtask

  task automatic test_rdw();
    logic [32:0] ra, rb, rc;
    do_write(8'd7, 32'h1234_5678, 4'b1111);
    we = 1'b1; waddr = 8'd7; wdata = 32'hFFFF_FFFF; be = 4'b0011;
    re = 1'b1; raddr = 8'd7;
    tick();
    we = 1'b0; re = 1'b0;
    checks++; if ({vld_a, dout_a} !== {1'b1, 32'h1234_5678}) begin failures++; $display("FAIL rdw_old_a: got %h want 112345678", {vld_a, dout_a}); end
    checks++; if ({vld_c, dout_c} !== {1'b1, 32'h1234_5678}) begin failures++; $display("FAIL rdw_old_c: got %h want 112345678", {vld_c, dout_c}); end
    tick();
    checks++; if ({vld_b, dout_b} !== {1'b1, 32'h1234_FFFF}) begin failures++; $display("FAIL rdw_new_b: got %h want 11234ffff", {vld_b, dout_b}); end
    // Write one cycle after the read must not reach the latency-2 output
    re = 1'b1; raddr = 8'd7;
    tick();
    re = 1'b0;
    we = 1'b1; waddr = 8'd7; wdata = 32'h0; be = 4'b1111;
    checks++; if ({vld_a, dout_a} !== {1'b1, 32'h1234_FFFF}) begin failures++; $display("FAIL rdw_mem_a: got %h want 11234ffff", {vld_a, dout_a}); end
    tick();
    we = 1'b0;
    checks++; if ({vld_b, dout_b} !== {1'b1, 32'h1234_FFFF}) begin failures++; $display("FAIL rdw_nofwd_b: got %h want 11234ffff", {vld_b, dout_b}); end
    // Write to address 8 alongside a read of address 7
    we = 1'b1; waddr = 8'd8; wdata = 32'hBEEF_0008; be = 4'b1111;
    do_read(8'd7, ra, rb, rc);
    checks++; if (rb !== {1'b1, 32'h0}) begin failures++; $display("FAIL indep_rd7_b: got %h want 100000000", rb); end
    checks++; if (ra !== {1'b1, 32'h0}) begin failures++; $display("FAIL indep_rd7_a: got %h want 100000000", ra); end
    do_read(8'd8, ra, rb, rc);
    checks++; if (rb !== {1'b1, 32'hBEEF_0008}) begin failures++; $display("FAIL indep_rd8_b: got %h want 1beef0008", rb); end
  endtask

  task automatic test_clear_runtime();
    int ra, rb, rc, stray;
    logic [32:0] xa, xb, xc;
    ra = 0; rb = 0; rc = 0; stray = 0;
    re = 1'b1; raddr = 8'd5; clear = 1'b1;
    tick();
    re = 1'b0; clear = 1'b0;
    checks++; if ({rdy_a, rdy_b, rdy_c} !== 3'b000) begin failures++; $display("FAIL clr_busy: got %b want 000", {rdy_a, rdy_b, rdy_c}); end
    checks++; if ({vld_a, dout_a} !== {1'b1, 32'hAA22_CC44}) begin failures++; $display("FAIL clr_inflight_a: got %h want 1aa22cc44", {vld_a, dout_a}); end
    for (int n = 1; n <= 400; n++) begin
      we = (n >= 150 && n < 160); re = we;
      waddr = 8'd10; wdata = 32'hCAFE_F00D; be = 4'b1111; raddr = 8'd10;
      clear = (n == 50);
      tick();
      if (n == 1) begin
        checks++; if ({vld_b, dout_b} !== {1'b1, 32'hAA22_CC44}) begin failures++; $display("FAIL clr_inflight_b: got %h want 1aa22cc44", {vld_b, dout_b}); end
      end else if (vld_b) stray++;
      if (vld_a || vld_c) stray++;
      if (ra == 0 && rdy_a) ra = n;
      if (rb == 0 && rdy_b) rb = n;
      if (rc == 0 && rdy_c) rc = n;
      if (ra != 0 && rb != 0 && rc != 0 && n >= 160) break;
    end
    we = 1'b0; re = 1'b0; clear = 1'b0;
    checks++; if (stray != 0) begin failures++; $display("FAIL clr_stray_valid: got %0d want 0", stray); end
    checks++; if (ra != 256) begin failures++; $display("FAIL clr_ready_a: got %0d want 256", ra); end
    checks++; if (rb != 256) begin failures++; $display("FAIL clr_ready_b: got %0d want 256", rb); end
    checks++; if (rc != 200) begin failures++; $display("FAIL clr_ready_c: got %0d want 200", rc); end
    do_read(8'd10, xa, xb, xc);
    checks++; if (xa !== {1'b1, 32'h0}) begin failures++; $display("FAIL clr_rd10_a: got %h want 100000000", xa); end
    checks++; if (xc !== {1'b1, FILL_C}) begin failures++; $display("FAIL clr_rd10_c: got %h want %h", xc, {1'b1, FILL_C}); end
    do_read(8'd5, xa, xb, xc);
    checks++; if (xb !== {1'b1, 32'h0}) begin failures++; $display("FAIL clr_rd5_b: got %h want 100000000", xb); end
  endtask

  task automatic test_reset_mid_clear();
    int ra, rb, rc;
    logic [32:0] xa, xb, xc;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int n = 1; n <= 100; n++) tick();
    rst = 1'b1;
    tick();
    checks++; if ({rdy_a, rdy_b, rdy_c} !== 3'b000) begin failures++; $display("FAIL rst_mid_ready: got %b want 000", {rdy_a, rdy_b, rdy_c}); end
    checks++; if ({vld_c, dout_c} !== 33'd0) begin failures++; $display("FAIL rst_mid_out_c: got %h want 0", {vld_c, dout_c}); end
    checks++; if ({vld_b, dout_b} !== 33'd0) begin failures++; $display("FAIL rst_mid_out_b: got %h want 0", {vld_b, dout_b}); end
    rst = 1'b0;
    wait_ready(ra, rb, rc);
    checks++; if (ra != 256) begin failures++; $display("FAIL rst_mid_ready_a: got %0d want 256", ra); end
    checks++; if (rc != 200) begin failures++; $display("FAIL rst_mid_ready_c: got %0d want 200", rc); end
    do_read(8'd250, xa, xb, xc);
    checks++; if (xc !== {1'b1, 32'h0}) begin failures++; $display("FAIL oor_rd250_c: got %h want 100000000", xc); end
    do_read(8'd199, xa, xb, xc);
    checks++; if (xc !== {1'b1, FILL_C}) begin failures++; $display("FAIL rd199_c: got %h want %h", xc, {1'b1, FILL_C}); end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; we = 1'b0; re = 1'b0;
    be = '0; waddr = '0; raddr = '0; wdata = '0;
    test_reset();
    test_byte_enable();
    test_back_to_back();
    test_rdw();
    test_clear_runtime();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_s2p1c_be.md
Name: ram_s2p1c_be

Overview:
- Simple dual-port RAM with one clock: port A writes, port B reads.
- Extends the basic s2p1c RAM with per-byte write enables, read-valid tracking and a selectable read latency of 1 or 2.
- Adds a selectable read-during-write policy and a hardware clear engine that fills the array after reset or on request.
- Used as the general buffer and scratchpad primitive under FIFOs, caches and register files.

Parameters:
- WORD_WIDTH, 32, data width in bits; must be a multiple of BYTE_WIDTH.
- WORD_COUNT, 256, number of words; need not be a power of two.
- BYTE_WIDTH, 8, bits per write-enable lane.
- READ_LATENCY, 1, cycles from accepted read to data; only 1 or 2 are legal, and elaboration fails otherwise.
- RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new data forwarded per byte.
- CLEAR_ON_RESET, 1, when 1 the clear engine runs after reset.
- CLEAR_VALUE, 0, WORD_WIDTH-bit fill pattern written by the clear engine.
- Derived: ADDR_WIDTH = max(1, $clog2(WORD_COUNT)), BE_WIDTH = WORD_WIDTH/BYTE_WIDTH.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- clear_i  in  1  pulse that starts a full-array clear.
- ready_o  out  1  high when the array accepts reads and writes (not clearing).
- we_a_i  in  1  write strobe.
- be_a_i  in  BE_WIDTH  byte enables; bit k covers data bits [k*BYTE_WIDTH +: BYTE_WIDTH].
- addr_a_i  in  ADDR_WIDTH  write address.
- data_a_i  in  WORD_WIDTH  write data.
- re_b_i  in  1  read strobe.
- addr_b_i  in  ADDR_WIDTH  read address.
- data_b_o  out  WORD_WIDTH  read data.
- valid_b_o  out  1  one-cycle pulse marking data_b_o valid.

Behaviour:
- Reset (rst_i sampled high):
  - valid_b_o=0, data_b_o=0, all pipeline valids=0, clear counter=0.
  - State goes to CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
  - ready_o is 0 in CLEAR and 1 in IDLE, driven from a register.
  - Array contents are not reset directly.
- FSM has two states, IDLE and CLEAR.
  - IDLE -> CLEAR when clear_i=1; the state is CLEAR on the next cycle.
  - In CLEAR, the engine writes CLEAR_VALUE to address cnt each cycle, with cnt running 0..WORD_COUNT-1.
  - After the write at cnt=WORD_COUNT-1, the FSM returns to IDLE and ready_o=1 on the following cycle.
  - A full clear occupies exactly WORD_COUNT cycles.
  - clear_i is ignored while in CLEAR; a clear does not restart mid-operation.
  - rst_i during CLEAR restarts the sequence from cnt=0 if CLEAR_ON_RESET=1, otherwise goes to IDLE with a partially cleared array.
- Write (ready_o=1, we_a_i=1, addr_a_i<WORD_COUNT):
  - Bytes with be_a_i[k]=1 are updated; the other bytes are retained.
  - be_a_i=0 is a legal no-op.
  - Writes are ignored while ready_o=0.
  - Writes to an address >= WORD_COUNT are ignored.
- Read (ready_o=1, re_b_i=1):
  - Read accepted in cycle N gives valid_b_o=1 and data_b_o in cycle N+READ_LATENCY.
  - Throughput is one read per cycle with no bubbles.
  - data_b_o holds its last value when valid_b_o=0.
  - Reads while ready_o=0 are dropped: no valid pulse, ever.
  - A read of an address >= WORD_COUNT returns 0 with valid_b_o=1.
- Reads already in the pipeline when clear_i arrives still complete with their sampled data.
- Read-during-write (same cycle, addr_a_i==addr_b_i, both strobes high):
  - RDW_MODE=0: the read returns the pre-write word.
  - RDW_MODE=1: the read returns data_a_i bytes where be_a_i=1 and old bytes elsewhere.
- READ_LATENCY=2 adds one output register stage.
  - No forwarding from writes issued in cycle N+1: the stage-2 data is the stage-1 value.
- Simultaneous write and read to different addresses are independent.
- Assertions are disabled while rst_i=1:
  - we_a_i, re_b_i and clear_i are never X.
  - When we_a_i=1, addr_a_i and be_a_i are known.
  - When re_b_i=1, addr_b_i is known.

Test Plan:
- Reset with CLEAR_ON_RESET=1, WORD_COUNT=256 -> ready_o=0 for 256 cycles then 1; reads of addresses 0..255 all return 0x00000000 with valid_b_o.
- Write 0xAABBCCDD to address 5 with be=4'b1111, then 0x11223344 with be=4'b0101 -> a read of address 5 returns 0xAA22CC44.
- Back-to-back reads of addresses 0,1,2 in consecutive cycles at READ_LATENCY=1 and at 2 -> valid_b_o high for 3 consecutive cycles starting at N+1 or N+2 respectively, with data in order.
- Same-cycle write of 0xFFFFFFFF with be=4'b0011 and read of address 7 holding 0x12345678 -> RDW_MODE=0 returns 0x12345678; RDW_MODE=1 returns 0x1234FFFF.
- clear_i pulse at runtime, then write and read attempts during CLEAR -> both are ignored with no valid pulse; after 256 cycles the previously written words read 0.
- rst_i asserted at cnt=100 mid-clear -> the clear restarts from 0 and ready_o rises exactly 256 cycles after reset deasserts; WORD_COUNT=200 -> a read of address 250 returns 0 with valid.
